// File: rtl/mnist_frame_loader.sv
// mnist_frame_loader: writer-side front end for the int4 MNIST engine.
// Streams 8-bit pixels into the engine's input RAM as quantized 4-bit
// values, starts the engine once a well-framed image is committed, and
// returns the predicted class over a valid/ready result port.
// Optional build macro: MNIST_LOADER_ROUND_EN selects round-to-nearest
// quantization; without it pixels are truncated.
module mnist_frame_loader #(
  parameter int NUM_PIXELS = 784,
  parameter int PIX_W      = 8,
  parameter int Q_W        = 4,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_last,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [Q_W-1:0]    ram_wdata,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic [3:0]        eng_class,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_class,
  output logic              frame_err,
  output logic [15:0]       frames_done
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_DRAIN,
    S_COMMIT,
    S_START,
    S_WAIT,
    S_RESULT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
  localparam int                SHIFT    = PIX_W - Q_W;

  // Map a full-range pixel onto the Q_W-bit RAM format, never exceeding all-ones.
  function automatic logic [Q_W-1:0] quantize(input logic [PIX_W-1:0] p);
`ifdef MNIST_LOADER_ROUND_EN
    logic [PIX_W:0] sum;
    logic [PIX_W:0] q_wide;
    sum    = {1'b0, p} + ((PIX_W+1)'(1) << (SHIFT - 1));
    q_wide = sum >> SHIFT;
    if (q_wide > (PIX_W+1)'((1 << Q_W) - 1)) begin
      return {Q_W{1'b1}};
    end
    return q_wide[Q_W-1:0];
`else
    return Q_W'(p >> SHIFT);
`endif
  endfunction

  state_t            state;
  state_t            state_nx;
  logic              running;
  logic              eng_done_p1;
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              at_last;
  logic              done_rise;

  // running holds s_ready low until the first clock after reset release
  assign s_ready   = running & ((state == S_LOAD) | (state == S_DRAIN));
  assign accept    = s_valid & s_ready;
  assign at_last   = (idx == LAST_IDX);
  // a done level left high from an earlier run never looks like a new rise
  assign done_rise = eng_done & ~eng_done_p1;
  assign eng_start = (state == S_START);
  assign res_valid = (state == S_RESULT);

  // State register, run flag and registered copy of eng_done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_LOAD;
      running     <= 1'b0;
      eng_done_p1 <= 1'b0;
    end else begin
      state       <= state_nx;
      running     <= 1'b1;
      eng_done_p1 <= eng_done;
    end
  end

  // Next-state logic: framing decisions on accepted beats, engine handshake
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD: begin
        if (accept) begin
          if (at_last) begin
            state_nx = s_last ? S_COMMIT : S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (accept && s_last) begin
          state_nx = S_LOAD;
        end
      end
      S_COMMIT: state_nx = S_START;
      S_START:  state_nx = S_WAIT;
      S_WAIT: begin
        if (done_rise) begin
          state_nx = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          state_nx = S_LOAD;
        end
      end
      default: state_nx = S_LOAD;
    endcase
  end

  // Beat write-out, pixel index, framing error pulse and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      ram_wen     <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      frame_err   <= 1'b0;
      res_class   <= '0;
      frames_done <= '0;
    end else begin
      ram_wen   <= 1'b0;
      frame_err <= 1'b0;
      if (state == S_LOAD && accept) begin
        if (s_last && !at_last) begin
          // short frame: the closing beat is not written, image is abandoned
          frame_err <= 1'b1;
          idx       <= '0;
        end else begin
          ram_wen   <= 1'b1;
          ram_addr  <= idx;
          ram_wdata <= quantize(s_data);
          if (at_last) begin
            // full image written; a missing s_last means the frame runs long
            idx       <= '0;
            frame_err <= ~s_last;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      end
      if (state == S_WAIT && done_rise) begin
        res_class   <= eng_class;
        frames_done <= frames_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mnist_frame_loader.sv
// tb_mnist_frame_loader: directed bench for mnist_frame_loader with a
// frame-level reference model compared against the DUT every cycle.
module tb_mnist_frame_loader;

  localparam int NPIX = 784;

  logic        clk;
  logic        reset_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        ram_wen;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_wdata;
  logic        eng_start;
  logic        eng_done;
  logic [3:0]  eng_class;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_class;
  logic        frame_err;
  logic [15:0] frames_done;

  int checks = 0;
  int errors = 0;

  mnist_frame_loader dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .eng_start(eng_start), .eng_done(eng_done), .eng_class(eng_class),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .frame_err(frame_err), .frames_done(frames_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Quantizer reference in plain integer arithmetic
  function automatic int mq(input int p);
`ifdef MNIST_LOADER_ROUND_EN
    return ((p + 8) / 16 > 15) ? 15 : (p + 8) / 16;
`else
    return p / 16;
`endif
  endfunction

  // Reference model: beat count within the frame, discard mode, and one
  // image in flight from commit until its result is taken.
  int       m_cnt = 0;
  bit       m_drop = 0, m_busy = 0, m_run = 0, m_wait = 0, m_stpend = 0, m_dprev = 0;
  bit       e_wen = 0, e_err = 0, e_start = 0, e_rv = 0;
  bit [9:0] e_addr = 0;
  bit [3:0] e_wdata = 0, e_class = 0;
  bit [15:0] e_frames = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt = 0; m_drop = 0; m_busy = 0; m_run = 0; m_wait = 0; m_stpend = 0; m_dprev = 0;
      e_wen = 0; e_err = 0; e_start = 0; e_rv = 0; e_addr = 0; e_wdata = 0;
      e_class = 0; e_frames = 0;
    end else begin
      bit rdy, old_rv, old_start;
      rdy = m_run && !m_busy;
      old_rv = e_rv;
      old_start = e_start;
      e_wen = 0;
      e_err = 0;
      if (old_rv && res_ready) begin
        e_rv = 0;
        m_busy = 0;
      end
      if (m_wait && eng_done && !m_dprev) begin
        m_wait = 0;
        e_rv = 1;
        e_class = eng_class;
        e_frames = e_frames + 1;
      end
      if (old_start) m_wait = 1;
      e_start = m_stpend;
      m_stpend = 0;
      if (rdy && s_valid) begin
        if (m_drop) begin
          if (s_last) m_drop = 0;
        end else if (s_last && m_cnt < NPIX - 1) begin
          e_err = 1;
          m_cnt = 0;
        end else begin
          e_wen = 1;
          e_addr = 10'(m_cnt);
          e_wdata = 4'(mq(int'(s_data)));
          if (m_cnt == NPIX - 1) begin
            m_cnt = 0;
            if (s_last) begin
              m_busy = 1;
              m_stpend = 1;
            end else begin
              e_err = 1;
              m_drop = 1;
            end
          end else begin
            m_cnt++;
          end
        end
      end
      m_dprev = eng_done;
      m_run = 1;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("s_ready", s_ready, m_run && !m_busy);
    chk("ram_wen", ram_wen, e_wen);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_wdata", ram_wdata, e_wdata);
    chk("frame_err", frame_err, e_err);
    chk("eng_start", eng_start, e_start);
    chk("res_valid", res_valid, e_rv);
    chk("res_class", res_class, e_class);
    chk("frames_done", frames_done, e_frames);
  end

  // Event counters used by the directed frame-level checks
  int wcnt = 0, ecnt = 0, scnt = 0;
  int w0, e0, s0;
  always @(negedge clk) begin
    if (ram_wen === 1'b1) wcnt++;
    if (frame_err === 1'b1) ecnt++;
    if (eng_start === 1'b1) scnt++;
  end

  task automatic snap();
    w0 = wcnt; e0 = ecnt; s0 = scnt;
  endtask

  task automatic counts_check(input string nm, input int nw, input int ne, input int ns);
    #1;
    chk({nm, "_writes"}, wcnt - w0, nw);
    chk({nm, "_errs"}, ecnt - e0, ne);
    chk({nm, "_starts"}, scnt - s0, ns);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    while (s_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("beat_accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  // Beats first..total-1 of a frame, s_last on the final one
  task automatic send_range(input int first, input int total, input int base, input int step);
    for (int i = first; i < total; i++) begin
      send_beat(8'(base + i * step), i == total - 1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    s_valid = 0; s_data = 0; s_last = 0;
    eng_done = 0; eng_class = 0; res_ready = 0;
    reset_n = 1;
    #1 reset_n = 0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_ram_wen", ram_wen, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_frames_done", frames_done, 0);
    chk("q_80", mq(128), 8);
    chk("q_f8", mq(248), 15);
`ifdef MNIST_LOADER_ROUND_EN
    chk("q_08", mq(8), 1);
`else
    chk("q_08", mq(8), 0);
`endif
    repeat (3) @(negedge clk);
    reset_n = 1;
    #1 chk("s_ready_before_clk", s_ready, 0);
    @(negedge clk);
    chk("s_ready_after_reset", s_ready, 1);

    // Nominal frame
    snap();
    send_range(0, NPIX, 8'h80, 0);
    chk("nom_last_wen", ram_wen, 1);
    chk("nom_last_addr", ram_addr, 783);
    chk("nom_last_wdata", ram_wdata, 8);
    chk("nom_start_t1", eng_start, 0);
    chk("nom_commit_ready", s_ready, 0);
    @(negedge clk);
    chk("nom_start_t2", eng_start, 1);
    @(negedge clk);
    chk("nom_start_t3", eng_start, 0);
    repeat (3) @(negedge clk);
    eng_class = 4'd7;
    eng_done = 1;
    @(negedge clk);
    chk("nom_res_valid", res_valid, 1);
    chk("nom_res_class", res_class, 7);
    chk("nom_frames", frames_done, 1);
    counts_check("nom", 784, 0, 1);

    // Result backpressure
    repeat (50) begin
      @(negedge clk);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_class", res_class, 7);
      chk("bp_s_ready", s_ready, 0);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("bp_release_ready", s_ready, 1);
    chk("bp_release_valid", res_valid, 0);

    // Short frame
    snap();
    send_range(0, 10, 8'h10, 8'h11);
    chk("short_err", frame_err, 1);
    chk("short_no_wen", ram_wen, 0);
    repeat (3) @(negedge clk);
    counts_check("short", 9, 1, 0);

    // Stale done: eng_done stays high from the previous run
    @(negedge clk);
    snap();
    send_beat(8'h18, 1'b0);
    chk("restart_addr", ram_addr, 0);
    chk("restart_wen", ram_wen, 1);
`ifdef MNIST_LOADER_ROUND_EN
    chk("restart_wdata", ram_wdata, 2);
`else
    chk("restart_wdata", ram_wdata, 1);
`endif
    send_range(1, NPIX, 8'h18, 8'h03);
    repeat (20) @(negedge clk);
    chk("stale_ignored", res_valid, 0);
    eng_done = 0;
    repeat (2) @(negedge clk);
    eng_class = 4'd3;
    eng_done = 1;
    @(negedge clk);
    chk("stale_res_valid", res_valid, 1);
    chk("stale_res_class", res_class, 3);
    chk("stale_frames", frames_done, 2);
    counts_check("stale", 784, 0, 1);
    @(negedge clk);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("stale_release_ready", s_ready, 1);

    // Long frame
    snap();
    send_range(0, 790, 8'h40, 8'h07);
    repeat (2) @(negedge clk);
    counts_check("long", 784, 1, 0);
    chk("long_ready", s_ready, 1);
    chk("long_last_addr", ram_addr, 783);
    chk("long_frames", frames_done, 2);

    // Reset in the middle of a frame
    @(negedge clk);
    eng_done = 0;
    for (int i = 0; i < 300; i++) send_beat(8'(i), 1'b0);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_ram_wen", ram_wen, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    chk("mid_rst_ram_wdata", ram_wdata, 0);
    chk("mid_rst_res_class", res_class, 0);
    chk("mid_rst_frames", frames_done, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    snap();
    send_beat(8'hFF, 1'b0);
    chk("post_rst_addr", ram_addr, 0);
    chk("post_rst_wdata", ram_wdata, 15);
    send_range(1, NPIX, 8'hFF, 0);
    repeat (4) @(negedge clk);
    eng_class = 4'd9;
    eng_done = 1;
    @(negedge clk);
    chk("post_rst_res_valid", res_valid, 1);
    chk("post_rst_res_class", res_class, 9);
    chk("post_rst_frames", frames_done, 1);
    counts_check("post_rst", 784, 0, 1);
    @(negedge clk);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("post_rst_release", s_ready, 1);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mnist_frame_loader.md
# mnist_frame_loader

Writer-side front end for the int4 MNIST inference engine. Accepts an 8-bit grayscale pixel stream over a valid/ready handshake, quantizes each pixel to 4 bits, and writes it into the engine's 784-entry input image RAM. Once a complete, well-framed image is committed, it pulses the engine's start, captures the predicted class on done, and presents that class on a valid/ready result port.

## Interface
Parameters:
- NUM_PIXELS, 784, pixels per frame (28x28)
- PIX_W, 8, input pixel width
- Q_W, 4, quantized pixel width written to RAM
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W >= NUM_PIXELS

Ports:
- Clock and reset (already decided): one clock `clk`; reset `reset_n` is asynchronous and active-low.
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- s_valid  in  1  pixel beat valid
- s_ready  out  1  loader can accept a beat
- s_data  in  PIX_W  unsigned pixel
- s_last  in  1  marks final pixel of frame
- ram_wen  out  1  input-RAM write enable
- ram_addr  out  ADDR_W  input-RAM write address
- ram_wdata  out  Q_W  quantized pixel
- eng_start  out  1  one-cycle start pulse to engine
- eng_done  in  1  engine done (level; may stay high between runs)
- eng_class  in  4  engine predicted class
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_class  out  4  captured class
- frame_err  out  1  one-cycle pulse on framing error
- frames_done  out  16  completed-frame counter

## Operation
- States: LOAD, DRAIN, COMMIT, START, WAIT, RESULT. Reset state is LOAD.
- LOAD:
  - s_ready = 1.
  - An accepted beat (s_valid & s_ready) at pixel index i registers ram_addr = i, ram_wdata = Q(s_data) and ram_wen = 1 for the following cycle. Then i increments.
  - Accepted beat with s_last = 1 and i == NUM_PIXELS-1: go to COMMIT and clear i.
  - Accepted beat with s_last = 1 and i < NUM_PIXELS-1 (short frame): pulse frame_err, clear i, stay in LOAD. The partial frame is discarded and no start is issued.
  - Accepted beat with i == NUM_PIXELS-1 and s_last = 0 (long frame): pulse frame_err, clear i, go to DRAIN.
- DRAIN: s_ready = 1 and no RAM writes. Beats are dropped until a beat with s_last = 1 is accepted, then return to LOAD.
- COMMIT: one cycle that lets the final RAM write land. s_ready = 0.
- START: eng_start = 1 for exactly one cycle, then WAIT.
- WAIT:
  - Rising edge of eng_done is detected against a registered copy of eng_done, so a done level left over from a previous run is ignored.
  - On the rise, capture eng_class into res_class, increment frames_done (wraps at 2^16), and go to RESULT.
- RESULT:
  - res_valid = 1 and res_class is held stable.
  - On res_valid & res_ready, go to LOAD.
  - s_ready = 0 until then; only one frame is in flight at a time.
- Quantization Q: Q_W-bit result derived from the PIX_W-bit pixel (see Configuration). It is always saturated to 2^Q_W-1.
- Reset values: s_ready = 0 during reset and 1 after. All other outputs, i and frames_done are 0.
- The engine itself is not reset by this block.

## Timing
- Last beat accepted at cycle T: ram_wen = 1 at T+1, COMMIT at T+1, eng_start = 1 at T+2.
- Each accepted beat produces exactly one ram_wen cycle, one cycle later. Back-to-back beats give back-to-back writes.
- eng_done rise sampled at cycle D: res_valid = 1 from D+1.
- Result accepted at cycle R: s_ready = 1 at R+1.
- frame_err is asserted in the cycle after the offending beat. For frames of 1..NUM_PIXELS beats, frame_err is mutually exclusive with ram_wen for that beat.
- Async reset mid-frame, mid-WAIT or mid-RESULT:
  - All outputs clear immediately.
  - The FSM returns to LOAD on the first clk after deassertion.
  - A partial frame is lost and any pending result is dropped.

## Configuration
- MNIST_LOADER_ROUND_EN defined: Q = min(2^Q_W-1, (p + 2^(PIX_W-Q_W-1)) >> (PIX_W-Q_W)), i.e. round to nearest. Examples: p = 0x08 gives 1; p = 0xF8 gives 15 (saturates).
- MNIST_LOADER_ROUND_EN not defined: Q = p >> (PIX_W-Q_W), i.e. truncation. Examples: p = 0x08 gives 0; p = 0xF8 gives 15.

## Test plan
- Nominal frame: 784 beats with pixel value 0x80, s_last on beat 784, no backpressure. Expect 784 writes to addresses 0..783 with wdata 8. eng_start fires exactly 2 cycles after the last beat. Drive eng_done high with class 7: res_valid on the next cycle, res_class = 7, frames_done = 1.
- Short frame: s_last on beat 10. Expect frame_err pulse, no eng_start, and ram_addr restarting at 0 on the next beat.
- Long frame: 790 beats with s_last only on beat 790. Expect frame_err after beat 784, no writes for beats 785..790, return to LOAD, no eng_start.
- Stale done: hold eng_done = 1 across two frames. The second frame produces a result only after eng_done falls and rises again.
- Result backpressure: hold res_ready = 0 for 50 cycles. res_valid and res_class stay stable, s_ready stays 0. After the res_ready handshake, s_ready = 1 on the next cycle.
- Reset mid-frame: assert reset_n = 0 after 300 beats. All outputs are 0 immediately. The next 784-beat frame writes from address 0 and completes normally.
